// File: rtl/clock_div_prog_pkg.sv
// Shared constants and ratio helpers for the programmable clock divider.
//   MIN_DIV     : smallest divide ratio a channel will ever run at
//   clamp_div() : maps a requested ratio of 0 or 1 up to MIN_DIV
//   high_time() : cycles the square wave stays high for ratio r, ceil(r/2)
package clock_div_prog_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  function automatic int unsigned high_time(input int unsigned r);
    return (r + 1) >> 1;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: counter, active ratio, shadow ratio, pending flag and
// registered outputs.
//   clk, reset     : system clock, synchronous active-high reset
//   en, sync       : run enable, phase restart strobe
//   div_load       : capture div_val into the shadow register
//   div_val        : requested ratio (0/1 clamp to 2)
//   div_out, tick  : registered square wave and once-per-period strobe
//   counter        : current count
//   pending        : shadow ratio waiting for the next wrap
module clock_div_chan
  import clock_div_prog_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 4,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 div_load,
  input  logic [CNT_WIDTH-1:0] div_val,
  output logic                 div_out,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 pending
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] ratio;
  logic [CNT_WIDTH-1:0] shadow;

  logic [CNT_WIDTH-1:0] load_val_c;
  logic [CNT_WIDTH-1:0] next_ratio_c;
  logic [CNT_WIDTH-1:0] cnt_inc_c;
  logic [CNT_WIDTH-1:0] hi_cur_c;
  logic [CNT_WIDTH-1:0] hi_next_c;
  logic                 wrap_c;

  // Ratio that takes over at the next apply point; a same-edge load wins
  // over an older shadow value.
  always_comb begin
    load_val_c   = CNT_WIDTH'(clamp_div(32'(div_val)));
    next_ratio_c = div_load ? load_val_c : (pending ? shadow : ratio);
    cnt_inc_c    = cnt + CNT_WIDTH'(1);
    hi_cur_c     = CNT_WIDTH'(high_time(32'(ratio)));
    hi_next_c    = CNT_WIDTH'(high_time(32'(next_ratio_c)));
    wrap_c       = (cnt == ratio - CNT_WIDTH'(1));
  end

  // Counter, ratio bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      ratio   <= CNT_WIDTH'(DEFAULT_DIV);
      shadow  <= CNT_WIDTH'(DEFAULT_DIV);
      pending <= 1'b0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (div_load) shadow <= load_val_c;
      if (!en) begin
        // Stopped channel: nothing to glitch, so apply any new ratio now.
        cnt     <= '0;
        ratio   <= next_ratio_c;
        pending <= 1'b0;
        div_out <= 1'b0;
        tick    <= 1'b0;
      end else if (sync) begin
        cnt     <= '0;
        ratio   <= next_ratio_c;
        pending <= 1'b0;
        div_out <= 1'b1;
        tick    <= 1'b0;
      end else if (wrap_c) begin
        cnt     <= '0;
        ratio   <= next_ratio_c;
        pending <= 1'b0;
        div_out <= (CNT_WIDTH'(0) < hi_next_c);
        tick    <= 1'b1;
      end else begin
        // Mid-period load is parked until the wrap to avoid runt pulses.
        cnt     <= cnt_inc_c;
        if (div_load) pending <= 1'b1;
        div_out <= (cnt_inc_c < hi_cur_c);
        tick    <= 1'b0;
      end
    end
  end

  assign counter = cnt;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider; NUM_CH independent channels
// sharing one clock and one sync strobe.
//   clk, reset : system clock, synchronous active-high reset
//   en         : per-channel run enable
//   sync       : restart all enabled channels at count 0
//   div_load   : per-channel shadow capture strobe
//   div_val    : packed requested ratios, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   div_out    : per-channel square wave
//   tick       : per-channel one-cycle strobe, once per period
//   counter    : packed current counts
//   pending    : per-channel shadow-waiting flag
module clock_div_prog
  import clock_div_prog_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 4,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          sync,
  input  logic [NUM_CH-1:0]             div_load,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   div_val,
  output logic [NUM_CH-1:0]             div_out,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH*CNT_WIDTH-1:0]   counter,
  output logic [NUM_CH-1:0]             pending
);

  // One divider per channel; buses are simple slices.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    clock_div_chan #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en[i]),
      .sync     (sync),
      .div_load (div_load[i]),
      .div_val  (div_val[i*CNT_WIDTH +: CNT_WIDTH]),
      .div_out  (div_out[i]),
      .tick     (tick[i]),
      .counter  (counter[i*CNT_WIDTH +: CNT_WIDTH]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_div_prog.sv
module tb_clock_div_prog;

  localparam int unsigned CW = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned DEF = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     en;
  logic              sync;
  logic [NC-1:0]     div_load;
  logic [NC*CW-1:0]  div_val;
  logic [NC-1:0]     div_out;
  logic [NC-1:0]     tick;
  logic [NC*CW-1:0]  counter;
  logic [NC-1:0]     pending;

  int n_vec = 0;
  int n_err = 0;

  // Reference: position within the current period plus ratio bookkeeping.
  int m_pos   [NC];
  int m_r     [NC];
  int m_sh    [NC];
  int m_pend  [NC];
  int m_out   [NC];
  int m_tick  [NC];

  clock_div_prog #(.CNT_WIDTH(CW), .NUM_CH(NC), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .div_load(div_load),
    .div_val(div_val), .div_out(div_out), .tick(tick), .counter(counter),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int req_ratio(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Apply one clock edge of the behavioural rules to the reference.
  task automatic model_edge();
    for (int c = 0; c < int'(NC); c++) begin
      int v, nr;
      logic [CW-1:0] sl;
      sl = div_val[c*CW +: CW];
      v  = req_ratio(int'(sl));
      nr = div_load[c] ? v : (m_pend[c] != 0 ? m_sh[c] : m_r[c]);
      if (reset) begin
        m_pos[c] = 0; m_r[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0;
        m_out[c] = 0; m_tick[c] = 0;
      end else begin
        if (div_load[c]) m_sh[c] = v;
        if (!en[c]) begin
          m_pos[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_r[c] = nr; m_pend[c] = 0;
        end else if (sync) begin
          m_pos[c] = 0; m_out[c] = 1; m_tick[c] = 0; m_r[c] = nr; m_pend[c] = 0;
        end else if (m_pos[c] == m_r[c] - 1) begin
          m_pos[c] = 0; m_tick[c] = 1; m_r[c] = nr; m_pend[c] = 0;
          m_out[c] = 1;  // first cycle of a period is always in the high phase
        end else begin
          m_pos[c] = m_pos[c] + 1; m_tick[c] = 0;
          if (div_load[c]) m_pend[c] = 1;
          m_out[c] = (m_pos[c] < (m_r[c] + 1) / 2) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < int'(NC); c++) begin
      logic [CW-1:0] cs;
      cs = counter[c*CW +: CW];
      chk($sformatf("div_out%0d", c), int'(div_out[c]), m_out[c]);
      chk($sformatf("tick%0d", c),    int'(tick[c]),    m_tick[c]);
      chk($sformatf("counter%0d", c), int'(cs),         m_pos[c]);
      chk($sformatf("pending%0d", c), int'(pending[c]), m_pend[c]);
    end
  endtask

  task automatic step(input logic r, input logic [NC-1:0] e, input logic s,
                      input logic [NC-1:0] ld, input logic [CW-1:0] v1,
                      input logic [CW-1:0] v0);
    @(negedge clk);
    reset = r; en = e; sync = s; div_load = ld; div_val = {v1, v0};
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input logic [NC-1:0] e);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 2'b00, 4'd0, 4'd0);
  endtask

  int hi_cnt;

  initial begin
    reset = 1'b1; en = '0; sync = 1'b0; div_load = '0; div_val = '0;
    for (int c = 0; c < int'(NC); c++) begin
      m_pos[c] = 0; m_r[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0;
      m_out[c] = 0; m_tick[c] = 0;
    end

    // Reset with both enabled, then default ratio 2 free-running.
    step(1'b1, 2'b11, 1'b0, 2'b00, 4'd0, 4'd0);
    step(1'b1, 2'b11, 1'b0, 2'b00, 4'd0, 4'd0);
    chk("reset_counter", int'(counter), 0);
    chk("reset_div_out", int'(div_out), 0);
    run(8, 2'b11);

    // Ch0 loaded with 5 while disabled, then enabled.
    step(1'b0, 2'b00, 1'b0, 2'b01, 4'd0, 4'd5);
    chk("ch0_load_idle_pending", int'(pending[0]), 0);
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b01, 1'b0, 2'b00, 4'd0, 4'd0);
      hi_cnt += int'(div_out[0]);
    end
    chk("ch0_r5_high_cycles", hi_cnt, 6);

    // Ch1 at ratio 4, reload to 7 mid-period.
    step(1'b0, 2'b01, 1'b0, 2'b10, 4'd4, 4'd0);
    step(1'b0, 2'b11, 1'b0, 2'b00, 4'd0, 4'd0);
    step(1'b0, 2'b11, 1'b0, 2'b10, 4'd7, 4'd0);
    chk("ch1_pending_set", int'(pending[1]), 1);
    run(16, 2'b11);

    // Clamp of 0 and 1, then maximum ratio.
    step(1'b0, 2'b00, 1'b0, 2'b11, 4'd1, 4'd0);
    run(6, 2'b11);
    step(1'b0, 2'b00, 1'b0, 2'b01, 4'd0, 4'd15);
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 2'b11, 1'b0, 2'b00, 4'd0, 4'd0);
      hi_cnt += int'(div_out[0]);
    end
    chk("ch0_r15_high_cycles", hi_cnt, 16);

    // Ratios 3 and 6, then sync to align.
    step(1'b0, 2'b00, 1'b0, 2'b11, 4'd6, 4'd3);
    run(4, 2'b11);
    step(1'b0, 2'b11, 1'b1, 2'b00, 4'd0, 4'd0);
    chk("sync_counter", int'(counter), 0);
    run(14, 2'b11);

    // Reset collides with a load; then en0 drops mid-period.
    run(2, 2'b11);
    step(1'b1, 2'b11, 1'b0, 2'b11, 4'd9, 4'd9);
    chk("reset_wins_pending", int'(pending), 0);
    run(3, 2'b11);
    step(1'b0, 2'b10, 1'b0, 2'b00, 4'd0, 4'd0);
    chk("disable_no_tick", int'(tick[0]), 0);
    run(3, 2'b11);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, s;
      logic [NC-1:0] e, ld;
      r  = ($urandom % 80) == 0;
      s  = ($urandom % 25) == 0;
      e  = '0;
      ld = '0;
      for (int c = 0; c < int'(NC); c++) begin
        e[c]  = ($urandom % 12) != 0;
        ld[c] = ($urandom % 7) == 0;
      end
      step(r, e, s, ld, 4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
